// File: rtl/rename_dispatch_latch_pkg.sv
// Shared types for the Rename -> Dispatch boundary: per-lane dispatch packet and
// the bundle (packets plus per-lane valid) held by the skid queue.
package rename_dispatch_latch_pkg;

    localparam int DISPATCH_WIDTH = 4;

    typedef struct packed {
        logic       valid;
        logic       ready;
        logic [6:0] seqNo;
        logic [5:0] phyDest;
        logic [4:0] opcode;
    } disPkt;

    typedef struct packed {
        disPkt [DISPATCH_WIDTH-1:0] pkt;
        logic  [DISPATCH_WIDTH-1:0] valid;
    } disBundle;

endpackage

// File: rtl/bundle_skid_q2.sv
// Two-entry circular skid queue, generic over the payload type. The full flag is
// registered so the upstream stall never sees a combinational path from downstream.
module bundle_skid_q2 #(
    parameter type T     = logic,
    parameter int  DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_i,
    input  logic       enq_i,
    input  logic       deq_i,
    input  T           enq_data_i,
    output T           head_data_o,
    output logic [1:0] count_o,
    output logic       full_o
);

    if (DEPTH != 2) begin : g_bad_depth
        $error("bundle_skid_q2 supports DEPTH == 2 only");
    end

    T           entry_q [2];
    T           entry_d [2];
    logic       head_q, head_d;
    logic [1:0] count_q, count_d;
    logic       full_q, full_d;
    logic       wr_idx;

    always_comb begin
        entry_d = entry_q;
        head_d  = head_q;
        count_d = count_q;
        // Tail slot is (head + count) mod 2; enqueue is never requested at count 2.
        wr_idx  = head_q ^ count_q[0];
        if (flush_i) begin
            head_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (enq_i) entry_d[wr_idx] = enq_data_i;
            if (deq_i) head_d = ~head_q;
            count_d = count_q + {1'b0, enq_i} - {1'b0, deq_i};
        end
        full_d = (count_d == 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            head_q     <= 1'b0;
            count_q    <= 2'd0;
            full_q     <= 1'b0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    assign head_data_o = entry_q[head_q];
    assign count_o     = count_q;
    assign full_o      = full_q;

endmodule

// File: rtl/rename_dispatch_latch.sv
// Rename -> Dispatch pipeline latch: gates enqueue/dequeue around a 2-entry bundle
// queue, gives flush priority, and counts cycles spent stalling Rename.
module rename_dispatch_latch
    import rename_dispatch_latch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       renameReady_i,
    input  disPkt [DISPATCH_WIDTH-1:0] disPacket_i,
    input  logic  [DISPATCH_WIDTH-1:0] laneActive_i,
    input  logic                       dispatchStall_i,
    output disPkt [DISPATCH_WIDTH-1:0] disPacket_o,
    output logic  [DISPATCH_WIDTH-1:0] laneValid_o,
    output logic                       bundleValid_o,
    output logic                       renameStall_o,
    output logic  [1:0]                occupancy_o,
    output logic  [CNT_W-1:0]          stallCycles_o
);

    logic             enq;
    logic             deq;
    logic             full;
    logic [1:0]       count;
    disBundle         enq_bundle;
    disBundle         head_bundle;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Lane validity comes only from laneActive_i; the packet's own valid bit is ignored.
    always_comb begin
        enq_bundle.pkt   = disPacket_i;
        enq_bundle.valid = laneActive_i;
        enq = renameReady_i & ~full & ~flush_i;
        deq = (count != 2'd0) & ~dispatchStall_i & ~flush_i;
    end

    bundle_skid_q2 #(
        .T     (disBundle),
        .DEPTH (DEPTH)
    ) u_skid_q (
        .clk         (clk),
        .rst_n       (reset),
        .flush_i     (flush_i),
        .enq_i       (enq),
        .deq_i       (deq),
        .enq_data_i  (enq_bundle),
        .head_data_o (head_bundle),
        .count_o     (count),
        .full_o      (full)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (full && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(renameReady_i && renameStall_o && enq))
                else $error("enqueue accepted while queue full");
        end
    end

    always_comb begin
        bundleValid_o = (count != 2'd0);
        laneValid_o   = bundleValid_o ? head_bundle.valid : '0;
        disPacket_o   = head_bundle.pkt;
        renameStall_o = full;
        occupancy_o   = count;
        stallCycles_o = stall_cnt_q;
    end

endmodule

// File: tb/tb_rename_dispatch_latch.sv
// Randomized scoreboard bench for rename_dispatch_latch: a queue model of held
// bundles predicts head payload, lane valids, occupancy, stall and stall count.
module tb_rename_dispatch_latch;
    import rename_dispatch_latch_pkg::*;

    localparam int W        = DISPATCH_WIDTH;
    localparam int CNT_W    = 4;
    localparam int BW       = $bits(disBundle);
    localparam int STAT_MAX = (1 << CNT_W) - 1;

    typedef disPkt [W-1:0] pkts_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush_i = 1'b0;
    logic             renameReady_i = 1'b0;
    pkts_t            disPacket_i = '0;
    logic [W-1:0]     laneActive_i = '0;
    logic             dispatchStall_i = 1'b0;
    pkts_t            disPacket_o;
    logic [W-1:0]     laneValid_o;
    logic             bundleValid_o;
    logic             renameStall_o;
    logic [1:0]       occupancy_o;
    logic [CNT_W-1:0] stallCycles_o;

    always #5 clk = ~clk;

    rename_dispatch_latch #(.DEPTH(2), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush_i         (flush_i),
        .renameReady_i   (renameReady_i),
        .disPacket_i     (disPacket_i),
        .laneActive_i    (laneActive_i),
        .dispatchStall_i (dispatchStall_i),
        .disPacket_o     (disPacket_o),
        .laneValid_o     (laneValid_o),
        .bundleValid_o   (bundleValid_o),
        .renameStall_o   (renameStall_o),
        .occupancy_o     (occupancy_o),
        .stallCycles_o   (stallCycles_o)
    );

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] pend_b = '0;
    logic          pend_push = 1'b0;
    int            mdl_stall = 0;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic pkts_t rand_pkts(input int seq);
        pkts_t      p;
        logic [31:0] r;
        for (int i = 0; i < W; i++) begin
            r = $urandom();
            p[i] = r[$bits(disPkt)-1:0];
            p[i].valid = 1'b1;
            p[i].seqNo = 7'(seq);
        end
        return p;
    endfunction

    // Apply this cycle's inputs and stage the bundle that Rename will hand over.
    task automatic drive(input logic rdy, input logic stl, input logic fl,
                         input logic [W-1:0] lanes, input pkts_t pk);
        disBundle b;
        renameReady_i   = rdy;
        dispatchStall_i = stl;
        flush_i         = fl;
        laneActive_i    = lanes;
        disPacket_i     = pk;
        b.pkt  = pk;
        b.valid = lanes;
        pend_b    = b;
        pend_push = rdy && !fl && (exp_q.size() < 2);
    endtask

    task automatic cycle(input logic rdy, input logic stl, input logic fl,
                         input logic [W-1:0] lanes, input pkts_t pk);
        @(posedge clk);
        #1;
        drive(rdy, stl, fl, lanes, pk);
    endtask

    // Monitor: compare what the DUT presents, then retire/accept per the model.
    always @(negedge clk) begin
        disBundle head;
        int       n;
        if (reset) begin
            n = exp_q.size();
            chk("occupancy", 128'(occupancy_o), 128'(n));
            chk("bundle_valid", 128'(bundleValid_o), 128'(n > 0));
            chk("rename_stall", 128'(renameStall_o), 128'(n == 2));
            chk("stall_cycles", 128'(stallCycles_o), 128'(mdl_stall));
            if (n > 0) begin
                head = exp_q[0];
                chk("lane_valid", 128'(laneValid_o), 128'(head.valid));
                chk("payload", 128'(disPacket_o), 128'(head.pkt));
            end else begin
                chk("lane_valid_idle", 128'(laneValid_o), 128'(0));
            end
            if (n == 2 && mdl_stall < STAT_MAX) mdl_stall++;
            if (flush_i) begin
                exp_q.delete();
            end else begin
                if (n > 0 && !dispatchStall_i) void'(exp_q.pop_front());
                if (pend_push) exp_q.push_back(pend_b);
            end
            pend_push = 1'b0;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Back-to-back bundles with no backpressure.
        drive(1'b1, 1'b0, 1'b0, 4'hF, rand_pkts(10));
        cycle(1'b1, 1'b0, 1'b0, 4'hF, rand_pkts(11));
        cycle(1'b1, 1'b0, 1'b0, 4'hF, rand_pkts(12));
        cycle(1'b0, 1'b0, 1'b0, 4'h0, '0);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, '0);

        // Fill under stall, then release and drain in order.
        cycle(1'b1, 1'b1, 1'b0, 4'hF, rand_pkts(10));
        cycle(1'b1, 1'b1, 1'b0, 4'hF, rand_pkts(11));
        cycle(1'b0, 1'b1, 1'b0, 4'h0, '0);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, '0);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, '0);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, '0);

        // Hold full long enough to saturate the stall counter.
        cycle(1'b1, 1'b1, 1'b0, 4'hF, rand_pkts(30));
        cycle(1'b1, 1'b1, 1'b0, 4'hF, rand_pkts(31));
        for (int i = 0; i < 24; i++) cycle(1'b1, 1'b1, 1'b0, 4'hF, rand_pkts(40 + i));
        chk("stall_saturated", 128'(stallCycles_o), 128'(STAT_MAX));

        // Flush while full with a bundle offered in the same cycle.
        cycle(1'b1, 1'b1, 1'b1, 4'hF, rand_pkts(70));
        cycle(1'b1, 1'b0, 1'b0, 4'hF, rand_pkts(71));
        cycle(1'b0, 1'b0, 1'b0, 4'h0, '0);

        // Partial lane activity.
        cycle(1'b1, 1'b0, 1'b0, 4'b0011, rand_pkts(80));
        cycle(1'b0, 1'b0, 1'b0, 4'h0, '0);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, '0);

        // Asynchronous reset mid-stream at count 1.
        cycle(1'b1, 1'b1, 1'b0, 4'hF, rand_pkts(90));
        cycle(1'b0, 1'b1, 1'b0, 4'h0, '0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, '0);
        #1;
        chk("rst_bundle_valid", 128'(bundleValid_o), 128'(0));
        chk("rst_lane_valid", 128'(laneValid_o), 128'(0));
        chk("rst_occupancy", 128'(occupancy_o), 128'(0));
        chk("rst_rename_stall", 128'(renameStall_o), 128'(0));
        chk("rst_stall_cycles", 128'(stallCycles_o), 128'(0));
        chk("rst_payload", 128'(disPacket_o), 128'(0));
        exp_q.delete();
        mdl_stall = 0;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 4'hF, rand_pkts(20));
        cycle(1'b0, 1'b0, 1'b0, 4'h0, '0);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, '0);

        // Randomized traffic with bursts of backpressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            logic       rdy, stl, fl;
            logic [3:0] lanes;
            rdy   = ($urandom_range(0, 99) < 70);
            stl   = ((i / 16) % 2 == 1) ? ($urandom_range(0, 99) < 75)
                                        : ($urandom_range(0, 99) < 25);
            fl    = ($urandom_range(0, 19) == 0);
            lanes = 4'($urandom_range(0, 15));
            cycle(rdy, stl, fl, lanes, rand_pkts($urandom_range(0, 127)));
        end
        cycle(1'b0, 1'b0, 1'b0, 4'h0, '0);
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
